// File: rtl/movement_arbiter.sv
// movement_arbiter: collision arbiter downstream of the falling-piece register.
// Checks the four proposed block coordinates against walls, floor and the
// locked-cell playfield, then answers commit / decline / steal. On steal the
// last committed piece is written into the playfield. Provides a registered
// colour read port for video.
// Optional feature macro: LINE_CLEAR_EN (full-row removal after each lock).
// Ports:
//   clk, reset (sync, active-low)
//   movement_request/intent, blk_color, P1..P4 blk_v/blk_h : proposed move
//   movement_commit (pulse), movement_declined, movement_steal : handshake
//   rd_v, rd_h -> rd_color (1-cycle latency) : video read port
//   game_over (sticky), lines_cleared (saturating count)
module movement_arbiter #(
   parameter int unsigned V_LO = 1,
   parameter int unsigned V_HI = 10,
   parameter int unsigned H_HI = 20
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       movement_request,
   input  logic       movement_intent,
   input  logic [2:0] blk_color,
   input  logic [4:0] P1blk_v,
   input  logic [4:0] P2blk_v,
   input  logic [4:0] P3blk_v,
   input  logic [4:0] P4blk_v,
   input  logic [4:0] P1blk_h,
   input  logic [4:0] P2blk_h,
   input  logic [4:0] P3blk_h,
   input  logic [4:0] P4blk_h,
   output logic       movement_commit,
   output logic       movement_declined,
   output logic       movement_steal,
   input  logic [4:0] rd_v,
   input  logic [4:0] rd_h,
   output logic [2:0] rd_color,
   output logic       game_over,
   output logic [7:0] lines_cleared
);
   localparam int unsigned NCOL = V_HI - V_LO + 1;
   localparam int unsigned NROW = H_HI + 1;
   localparam int unsigned CW   = $clog2(NCOL);
   localparam int unsigned RW   = $clog2(NROW);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_CHECK   = 3'd1;
   localparam logic [2:0] S_WAITLOW = 3'd2;
   localparam logic [2:0] S_DECL    = 3'd3;
   localparam logic [2:0] S_LOCK    = 3'd4;
   localparam logic [2:0] S_SDROP   = 3'd5;
   localparam logic [2:0] S_HALT    = 3'd6;
`ifdef LINE_CLEAR_EN
   localparam logic [2:0] S_CLEAR   = 3'd7;
`endif

   logic [2:0] field_q [0:NROW-1][0:NCOL-1];

   logic [2:0] state_q, state_d;
   logic [1:0] cnt_q, cnt_d;
   logic       hit_q, hit_d;
   logic       lat_intent_q, lat_intent_d;
   logic [2:0] lat_color_q, lat_color_d;
   logic [4:0] lat_v_q [4];
   logic [4:0] lat_v_d [4];
   logic [4:0] lat_h_q [4];
   logic [4:0] lat_h_d [4];
   logic [2:0] kept_color_q, kept_color_d;
   logic [4:0] kept_v_q [4];
   logic [4:0] kept_v_d [4];
   logic [4:0] kept_h_q [4];
   logic [4:0] kept_h_d [4];
   logic       kept_ok_q, kept_ok_d;
   logic       commit_q, commit_d;
   logic       declined_q, declined_d;
   logic       steal_q, steal_d;
   logic       game_over_q, game_over_d;
   logic [2:0] rd_color_q, rd_color_d;

   logic [4:0]    cur_v, cur_h, lock_v, lock_h;
   logic          cur_hit_c, lock_in_range;
   logic [CW-1:0] lock_col;
   logic          lock_we_c;
`ifdef LINE_CLEAR_EN
   logic [RW-1:0] row_q, row_d;
   logic [7:0]    lines_q, lines_d;
   logic          row_full_c, shift_c;
`endif

   // Collision test for the block selected by the check counter
   always_comb begin
      cur_v     = lat_v_q[cnt_q];
      cur_h     = lat_h_q[cnt_q];
      cur_hit_c = 1'b1;
      if (cur_v >= 5'(V_LO) && cur_v <= 5'(V_HI) && cur_h <= 5'(H_HI))
         cur_hit_c = (field_q[RW'(cur_h)][CW'(cur_v - 5'(V_LO))] != 3'd0);
   end

   // Target cell of the kept block being locked this cycle
   always_comb begin
      lock_v        = kept_v_q[cnt_q];
      lock_h        = kept_h_q[cnt_q];
      lock_col      = CW'(lock_v - 5'(V_LO));
      lock_in_range = (lock_v >= 5'(V_LO) && lock_v <= 5'(V_HI) && lock_h <= 5'(H_HI));
   end

   // Video read port; out-of-range addresses read as empty
   always_comb begin
      rd_color_d = 3'd0;
      if (rd_v >= 5'(V_LO) && rd_v <= 5'(V_HI) && rd_h <= 5'(H_HI))
         rd_color_d = field_q[RW'(rd_h)][CW'(rd_v - 5'(V_LO))];
   end

`ifdef LINE_CLEAR_EN
   always_comb begin
      row_full_c = 1'b1;
      for (int c = 0; c < NCOL; c++)
         if (field_q[row_q][c] == 3'd0) row_full_c = 1'b0;
   end
`endif

   // Next-state and output logic
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      hit_d        = hit_q;
      lat_intent_d = lat_intent_q;
      lat_color_d  = lat_color_q;
      lat_v_d      = lat_v_q;
      lat_h_d      = lat_h_q;
      kept_color_d = kept_color_q;
      kept_v_d     = kept_v_q;
      kept_h_d     = kept_h_q;
      kept_ok_d    = kept_ok_q;
      commit_d     = 1'b0;
      declined_d   = declined_q;
      steal_d      = steal_q;
      game_over_d  = game_over_q;
      lock_we_c    = 1'b0;
`ifdef LINE_CLEAR_EN
      row_d        = row_q;
      lines_d      = lines_q;
      shift_c      = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            declined_d = 1'b0;
            steal_d    = 1'b0;
            if (movement_request && !game_over_q) begin
               lat_intent_d = movement_intent;
               lat_color_d  = blk_color;
               lat_v_d[0] = P1blk_v; lat_v_d[1] = P2blk_v;
               lat_v_d[2] = P3blk_v; lat_v_d[3] = P4blk_v;
               lat_h_d[0] = P1blk_h; lat_h_d[1] = P2blk_h;
               lat_h_d[2] = P3blk_h; lat_h_d[3] = P4blk_h;
               cnt_d   = 2'd0;
               hit_d   = 1'b0;
               state_d = S_CHECK;
            end
         end
         S_CHECK: begin
            hit_d = hit_q | cur_hit_c;
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
               if (!(hit_q | cur_hit_c)) begin
                  commit_d     = 1'b1;
                  kept_color_d = lat_color_q;
                  kept_v_d     = lat_v_q;
                  kept_h_d     = lat_h_q;
                  kept_ok_d    = 1'b1;
                  state_d      = S_WAITLOW;
               end else if (lat_intent_q) begin
                  declined_d = 1'b1;
                  state_d    = S_DECL;
               end else if (kept_ok_q) begin
                  steal_d = 1'b1;
                  state_d = S_LOCK;
               end else begin
                  game_over_d = 1'b1;
                  state_d     = S_HALT;
               end
            end
         end
         S_WAITLOW: begin
            if (!movement_request) state_d = S_IDLE;
         end
         S_DECL: begin
            if (!movement_request) begin
               declined_d = 1'b0;
               state_d    = S_IDLE;
            end
         end
         S_LOCK: begin
            lock_we_c = lock_in_range;
            cnt_d     = cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
               kept_ok_d = 1'b0;
`ifdef LINE_CLEAR_EN
               row_d   = RW'(H_HI);
               state_d = S_CLEAR;
`else
               state_d = S_SDROP;
`endif
            end
         end
`ifdef LINE_CLEAR_EN
         // Full row collapses the field above it; the same row is rescanned
         S_CLEAR: begin
            if (row_full_c) begin
               shift_c = 1'b1;
               if (lines_q != 8'hFF) lines_d = lines_q + 8'd1;
            end else if (row_q == '0) begin
               state_d = S_SDROP;
            end else begin
               row_d = row_q - RW'(1);
            end
         end
`endif
         S_SDROP: begin
            if (!movement_request) begin
               steal_d = 1'b0;
               state_d = S_IDLE;
            end
         end
         S_HALT: begin
            declined_d = 1'b0;
            steal_d    = 1'b0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and control registers
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         cnt_q        <= 2'd0;
         hit_q        <= 1'b0;
         lat_intent_q <= 1'b0;
         lat_color_q  <= 3'd0;
         kept_color_q <= 3'd0;
         kept_ok_q    <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            lat_v_q[i]  <= 5'd0;
            lat_h_q[i]  <= 5'd0;
            kept_v_q[i] <= 5'd0;
            kept_h_q[i] <= 5'd0;
         end
         commit_q     <= 1'b0;
         declined_q   <= 1'b0;
         steal_q      <= 1'b0;
         game_over_q  <= 1'b0;
         rd_color_q   <= 3'd0;
`ifdef LINE_CLEAR_EN
         row_q        <= '0;
         lines_q      <= 8'd0;
`endif
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         hit_q        <= hit_d;
         lat_intent_q <= lat_intent_d;
         lat_color_q  <= lat_color_d;
         lat_v_q      <= lat_v_d;
         lat_h_q      <= lat_h_d;
         kept_color_q <= kept_color_d;
         kept_v_q     <= kept_v_d;
         kept_h_q     <= kept_h_d;
         kept_ok_q    <= kept_ok_d;
         commit_q     <= commit_d;
         declined_q   <= declined_d;
         steal_q      <= steal_d;
         game_over_q  <= game_over_d;
         rd_color_q   <= rd_color_d;
`ifdef LINE_CLEAR_EN
         row_q        <= row_d;
         lines_q      <= lines_d;
`endif
      end
   end

   // Playfield storage: lock writes and row collapse
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int r = 0; r < NROW; r++)
            for (int c = 0; c < NCOL; c++)
               field_q[r][c] <= 3'd0;
      end else if (lock_we_c) begin
         field_q[RW'(lock_h)][lock_col] <= kept_color_q;
      end
`ifdef LINE_CLEAR_EN
      else if (shift_c) begin
         for (int r = 1; r < NROW; r++)
            if (RW'(r) <= row_q)
               for (int c = 0; c < NCOL; c++)
                  field_q[r][c] <= field_q[r-1][c];
         for (int c = 0; c < NCOL; c++)
            field_q[0][c] <= 3'd0;
      end
`endif
   end

   assign movement_commit   = commit_q;
   assign movement_declined = declined_q;
   assign movement_steal    = steal_q;
   assign game_over         = game_over_q;
   assign rd_color          = rd_color_q;
`ifdef LINE_CLEAR_EN
   assign lines_cleared     = lines_q;
`else
   assign lines_cleared     = 8'd0;
`endif

endmodule
